// File: rtl/keypad_scan_if.sv
// Keypad scanner bundle: matrix lines plus the press-event handshake.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  modport master (
    input  col, key_ready,
    output row, key_code, key_valid, key_held, overrun
  );

  modport slave (
    output col, key_ready,
    input  row, key_code, key_valid, key_held, overrun
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with debounce, ghost rejection and a one-deep
// press-event register with valid/ready handshake.
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat of a held key.
module keypad_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV       = 16'd50_000,
  parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4,
  parameter logic [7:0]  REPEAT_DELAY   = 8'd50,
  parameter logic [7:0]  REPEAT_RATE    = 8'd10
) (
  input  logic           clk,
  input  logic           rst,
  keypad_scan_if.master  kp
);

  function automatic logic [4:0] f_popcnt(input logic [15:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, m[i]};
    return n;
  endfunction

  function automatic logic [3:0] f_encode(input logic [15:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) c = 4'(i);
    return c;
  endfunction

  logic [3:0]  r_col_s1, r_col_s2;
  logic [15:0] r_dwell;
  logic [1:0]  r_row_idx;
  logic [15:0] r_raw, r_prev, r_map;
  logic [3:0]  r_stable;
  logic        r_evt_p1;
  logic [3:0]  r_evt_code_p1;
  logic        r_valid;
  logic [3:0]  r_code;
  logic        r_overrun;

  logic        w_sample, w_scan_end, w_load;
  logic [15:0] w_snap;
  logic [3:0]  w_stable_nxt;
  logic        w_new_single, w_held;
  logic [3:0]  w_new_code, w_res_code;
  logic        w_res_change, w_press_evt;
  logic        w_evt;
  logic [3:0]  w_evt_code;

  // Scan bookkeeping, snapshot assembly and debounce decisions
  always_comb begin
    w_sample     = (r_dwell == SCAN_DIV - 16'd1);
    w_scan_end   = w_sample && (r_row_idx == 2'd3);
    w_snap       = r_raw;
    w_snap[{r_row_idx, 2'b00} +: 4] = ~r_col_s2;
    w_stable_nxt = (w_snap != r_prev) ? 4'd0 :
                   (r_stable == 4'd15) ? 4'd15 : r_stable + 4'd1;
    w_load       = w_scan_end && (w_stable_nxt == DEBOUNCE_SCANS - 4'd1);
    w_new_single = (f_popcnt(w_snap) == 5'd1);
    w_new_code   = f_encode(w_snap);
    w_held       = (f_popcnt(r_map) == 5'd1);
    w_res_code   = f_encode(r_map);
    w_res_change = w_load && ((w_new_single != w_held) ||
                              (w_new_single && (w_new_code != w_res_code)));
    w_press_evt  = w_load && w_new_single &&
                   (!w_held || (w_new_code != w_res_code));
  end

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] r_rep;
  logic       r_rep_armed;
  logic [7:0] w_rep_nxt;
  logic       w_rep_hit;

  // Repeat target: first REPEAT_DELAY scans, then every REPEAT_RATE scans
  always_comb begin
    w_rep_nxt = r_rep + 8'd1;
    w_rep_hit = w_scan_end && w_held && !w_res_change &&
                (w_rep_nxt == (r_rep_armed ? REPEAT_RATE : REPEAT_DELAY));
  end

  // Full-scan counter while one key stays resolved; restarts on any change
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_scan_end) begin
      if (w_res_change || !w_held) begin
        r_rep       <= '0;
        r_rep_armed <= 1'b0;
      end else if (w_rep_hit) begin
        r_rep       <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep <= w_rep_nxt;
      end
    end
  end

  assign w_evt      = w_press_evt || w_rep_hit;
  assign w_evt_code = w_press_evt ? w_new_code : w_res_code;
`else
  assign w_evt      = w_press_evt;
  assign w_evt_code = w_new_code;
`endif

  // Two-flop column synchronizer; idles at the released (pulled-up) level
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= kp.col;
      r_col_s2 <= r_col_s1;
    end
  end

  // Row dwell counter and row index; advance after the sampling cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dwell   <= '0;
      r_row_idx <= '0;
    end else if (w_sample) begin
      r_dwell   <= '0;
      r_row_idx <= r_row_idx + 2'd1;
    end else begin
      r_dwell <= r_dwell + 16'd1;
    end
  end

  // Snapshot capture, scan-to-scan comparison and debounced map load
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_raw    <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_map    <= '0;
    end else if (w_sample) begin
      r_raw <= w_snap;
      if (r_row_idx == 2'd3) begin
        r_prev   <= w_snap;
        r_stable <= w_stable_nxt;
        if (w_load) r_map <= w_snap;
      end
    end
  end

  // p1: event raised at the scan's final sample, presented one edge later
  always_ff @(posedge clk) begin
    if (!rst) r_evt_p1 <= 1'b0;
    else      r_evt_p1 <= w_evt;
  end

  // Event code travels beside its flag
  always_ff @(posedge clk) begin
    r_evt_code_p1 <= w_evt_code;
  end

  // Output event register: load, consume, or drop-and-flag overrun
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_overrun <= 1'b0;
    end else if (r_evt_p1) begin
      if (!r_valid || kp.key_ready) begin
        r_valid <= 1'b1;
        r_code  <= r_evt_code_p1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && kp.key_ready) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end
  end

  assign kp.row       = ~(4'b0001 << r_row_idx);
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = w_held;
  assign kp.overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a physical 4x4 matrix model drives col
// from row, and a scan-level reference model predicts the outputs.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;
  localparam int DIV      = 4;
  localparam int DEB      = 3;
  localparam int RD       = 4;
  localparam int RR       = 2;
  localparam int SCAN_CYC = 4 * DIV;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  w_col;
  int          n_chk  = 0;
  int          n_fail = 0;

  keypad_scan_if u_if();

  keypad_scan_ctrl #(
    .SCAN_DIV      (16'(DIV)),
    .DEBOUNCE_SCANS(4'(DEB)),
    .REPEAT_DELAY  (8'(RD)),
    .REPEAT_RATE   (8'(RR))
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .kp (u_if.master)
  );

  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls column c low while row r is driven low
  always_comb begin
    w_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!u_if.row[r] && keys[r*4+c]) w_col[c] = 1'b0;
  end
  assign u_if.col = w_col;

  // Reference model state
  logic [15:0] m_last;
  int          m_run;
  logic        m_single;
  logic [3:0]  m_rcode;
  int          m_elapsed;
  logic        m_evt_due;
  logic [3:0]  m_evt_code;
  logic        m_valid;
  logic [3:0]  m_code;
  logic        m_over;

  task automatic chk_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int f_count(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  function automatic logic [3:0] f_index(input logic [15:0] m);
    logic [3:0] idx = '0;
    for (int i = 0; i < 16; i++) if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  task automatic model_reset();
    m_last = '0; m_run = 1; m_single = 1'b0; m_rcode = '0; m_elapsed = 0;
    m_evt_due = 1'b0; m_evt_code = '0; m_valid = 1'b0; m_code = '0; m_over = 1'b0;
  endtask

  // Consumer-side effect of one clock edge
  task automatic model_edge();
    if (m_evt_due) begin
      if (!m_valid || u_if.key_ready) begin
        m_valid = 1'b1;
        m_code  = m_evt_code;
      end else begin
        m_over = 1'b1;
      end
      m_evt_due = 1'b0;
    end else if (m_valid && u_if.key_ready) begin
      m_valid = 1'b0;
      m_code  = '0;
    end
  endtask

  // Outcome of one complete scan whose snapshot is snap
  task automatic model_scan_end(input logic [15:0] snap);
    logic changed = 1'b0;
    logic nsingle;
    if (snap == m_last) m_run = (m_run < 16) ? m_run + 1 : 16;
    else                m_run = 1;
    m_last = snap;
    if (m_run == DEB) begin
      nsingle = (f_count(snap) == 1);
      if (nsingle && (!m_single || f_index(snap) != m_rcode)) begin
        m_evt_due  = 1'b1;
        m_evt_code = f_index(snap);
      end
      changed  = (nsingle != m_single) || (nsingle && f_index(snap) != m_rcode);
      m_single = nsingle;
      if (nsingle) m_rcode = f_index(snap);
    end
`ifdef KEYPAD_REPEAT_EN
    if (changed) m_elapsed = 0;
    else if (m_single) begin
      m_elapsed++;
      if (m_elapsed >= RD && ((m_elapsed - RD) % RR) == 0) begin
        m_evt_due  = 1'b1;
        m_evt_code = m_rcode;
      end
    end else m_elapsed = 0;
`else
    if (changed) m_elapsed = 0;
`endif
  endtask

  // One full scan with key set k; mode 0 ready low, 1 high, 2 random, 3 high from cycle 2
  task automatic do_scan(input logic [15:0] k, input int mode);
    logic [3:0] erow;
    keys = k;
    for (int c = 0; c < SCAN_CYC; c++) begin
      case (mode)
        0:       u_if.key_ready = 1'b0;
        1:       u_if.key_ready = 1'b1;
        2:       u_if.key_ready = 1'($urandom_range(0, 1));
        default: u_if.key_ready = (c >= 2);
      endcase
      @(posedge clk);
      model_edge();
      if (c == SCAN_CYC - 1) model_scan_end(k);
      #1;
      erow = 4'hF;
      erow[((c + 1) / DIV) % 4] = 1'b0;
      chk_eq("row", 16'(u_if.row), 16'(erow));
      chk_eq("key_valid", 16'(u_if.key_valid), 16'(m_valid));
      if (m_valid) chk_eq("key_code", 16'(u_if.key_code), 16'(m_code));
      chk_eq("key_held", 16'(u_if.key_held), 16'(m_single));
      chk_eq("overrun", 16'(u_if.overrun), 16'(m_over));
    end
  endtask

  task automatic do_scans(input logic [15:0] k, input int n, input int mode);
    for (int i = 0; i < n; i++) do_scan(k, mode);
  endtask

  // Run ncyc cycles into a scan, then apply reset and check the reset state
  task automatic do_reset(input int ncyc);
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
    u_if.key_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk_eq("rst_row", 16'(u_if.row), 16'h000E);
    chk_eq("rst_valid", 16'(u_if.key_valid), 16'h0);
    chk_eq("rst_code", 16'(u_if.key_code), 16'h0);
    chk_eq("rst_held", 16'(u_if.key_held), 16'h0);
    chk_eq("rst_overrun", 16'(u_if.overrun), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] pat;
    int          sel;
    u_if.key_ready = 1'b0;
    model_reset();
    do_reset(0);

    do_scans(16'h0000, 2, 2);                     // idle row sweep
    do_scans(16'h0200, 5, 0);                     // key 9 held, no consumer
    do_scans(16'h0000, 3, 1);

    for (int i = 0; i < 6; i++)                   // bouncing key 0
      do_scan((i % 2 == 0) ? 16'h0001 : 16'h0000, 2);
    do_scans(16'h0001, 3, 2);
    do_scans(16'h0000, 3, 1);

    do_scans(16'h0020, 3, 0);                     // key 5
    do_scans(16'h0000, 3, 0);
    do_scans(16'h0040, 3, 0);                     // key 6 while 5 pending
    do_scan(16'h0040, 3);
    do_scans(16'h0000, 3, 1);

    do_scans(16'h0080, 3, 0);                     // key 7 pending, then reset
    do_scan(16'h0080, 0);
    do_reset(5);

    do_scans(16'h0006, 3, 1);                     // keys 1+2: ghost
    do_scans(16'h0002, 3, 1);                     // release 2
    do_scans(16'h0000, 3, 1);

    do_scans(16'h0008, 10, 1);                    // key 3 held long
    do_scans(16'h0000, 3, 1);

    for (int g = 0; g < 12; g++) begin
      sel = int'($urandom_range(0, 3));
      pat = 16'(1) << $urandom_range(0, 15);
      if (sel == 0) pat = '0;
      else if (sel == 3) pat = pat | (16'(1) << $urandom_range(0, 15));
      do_scans(pat, int'($urandom_range(1, 5)), 2);
      if (g == 6) do_reset(int'($urandom_range(1, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50_000, clock cycles each row is driven (row dwell); legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4'd4, consecutive identical full scans required to accept a matrix state; legal range 1..15.
REQ-003 SHALL have parameters REPEAT_DELAY, default 8'd50, and REPEAT_RATE, default 8'd10, both counted in full scans; used only under KEYPAD_REPEAT_EN.
REQ-004 clk  input  1  system clock; the single clock domain.
REQ-005 rst  input  1  reset; synchronous and active-low.
REQ-006 col  input  4  matrix column lines, active-low (pulled up), asynchronous to clk.
REQ-007 row  output  4  matrix row drive, active-low one-hot.
REQ-008 key_code  output  4  code of the pressed key, row_index*4 + col_index.
REQ-009 key_valid  output  1  key_code holds an unconsumed press event.
REQ-010 key_ready  input  1  consumer accepts the event when key_valid and key_ready are both 1 on a clk edge.
REQ-011 key_held  output  1  debounced state has exactly one key pressed.
REQ-012 overrun  output  1  sticky; a press event was dropped because the previous event was still pending.

Function
REQ-013 col SHALL pass through a two-flop synchronizer before use.
REQ-014 Row drive SHALL cycle 1110, 1101, 1011, 0111, 1110..., with each pattern held for exactly SCAN_DIV cycles; one full scan SHALL last 4*SCAN_DIV cycles.
REQ-015 The synchronized columns SHALL be sampled in the last dwell cycle of each row (dwell counter = SCAN_DIV-1) into a 16-bit raw snapshot; bit row*4+col = 1 means pressed.
REQ-016 On the last-row sample, the completed snapshot SHALL be compared with the previous completed snapshot: equal -> stable counter +1, saturating at 15; different -> stable counter cleared to 0.
REQ-017 When the stable counter reaches DEBOUNCE_SCANS-1, meaning DEBOUNCE_SCANS identical scans, the snapshot SHALL be loaded into the debounced map.
REQ-018 Resolution: debounced map popcount 0 -> no key; 1 -> single key with that code; 2 or more -> ghost state, key_held=0, and no event is generated.
REQ-019 A press event SHALL be generated on the debounced-map update in which the resolved state changes from not-single to single, or from single key A to single key B.
REQ-020 Event latency: key_valid SHALL rise on the clk edge following the accepting scan's final sample, with key_code loaded in the same edge.
REQ-021 key_valid SHALL remain high and key_code SHALL remain stable until the handshake; both SHALL clear or update only at the handshake edge.
REQ-022 If a new event and the handshake occur on the same edge, the new event SHALL be loaded and key_valid SHALL stay 1.
REQ-023 If a new event occurs while key_valid=1 and key_ready=0, the new event SHALL be dropped and overrun SHALL be set; overrun SHALL clear only on reset.
REQ-024 Key release SHALL generate no event; key_held SHALL fall on the debounced-map update that removes the key.

Reset
REQ-025 While rst=0 at a clk edge: row=4'b1110, key_valid=0, key_code=0, key_held=0, overrun=0; dwell counter, row index, stable counter, repeat counter and synchronizer SHALL be cleared; raw snapshot, previous snapshot and debounced map SHALL be cleared to all-released.
REQ-026 Reset asserted mid-scan or with an event pending SHALL discard all in-flight state; the first full scan after reset begins at row 0.

Configuration
REQ-027 Macro KEYPAD_REPEAT_EN defined: while a single key stays resolved, a repeat counter counts full scans; a repeat press event SHALL be issued after REPEAT_DELAY scans and then every REPEAT_RATE scans; repeat events follow REQ-021..023; any change of resolved state restarts the count.
REQ-028 KEYPAD_REPEAT_EN undefined: exactly one event per press; repeat counter and REPEAT_* logic SHALL be absent.

Verification (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2)
REQ-029 Reset then idle columns 1111 -> row sequence 1110, 1101, 1011, 0111 with 4 cycles each, repeating; key_valid stays 0.
REQ-030 Hold key row 2 / col 1 for 5 scans, key_ready=0 -> key_valid rises after scan 3 with key_code=9; key_held=1; one event only with the macro off.
REQ-031 Key row 0 / col 0 bouncing on alternate scans for 6 scans, then stable -> no event until 3 identical scans, then key_code=0.
REQ-032 Press key 5, release, then press key 6 with key_ready=0 -> key_code stays 5 and overrun=1; assert key_ready -> key_valid falls.
REQ-033 Press keys 1 and 2 together -> no event, key_held=0; release key 2 -> event with key_code=1.
REQ-034 KEYPAD_REPEAT_EN defined, key 3 held for 10 scans, key_ready=1 -> events after scans 3, 7 and 9.
